// File: rtl/ccp_pkg.sv
// Shared definitions for the coprocessor command arbiter: command classes,
// idle word, arbiter states and the header-to-burst-length table.
package ccp_pkg;

  typedef enum logic [1:0] {
    CLS_READ  = 2'b00,
    CLS_WRITE = 2'b01,
    CLS_KEY   = 2'b10,
    CLS_NOP   = 2'b11
  } cmd_class_e;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_IDLE,
    ST_COLLECT,
    ST_ISSUE,
    ST_RUN,
    ST_GAP
  } arb_state_e;

  localparam logic [31:0] NOP_WORD     = 32'hC000_0000;
  localparam int          MAX_WR_BURST = 14;

  // Key-expansion commands only decode hdr[3:0]; all other classes use hdr[4:0].
  function automatic logic [6:0] burst_len(input logic [31:0] hdr);
    logic [6:0] len;
    len = 7'd1;
    if (hdr[31:30] == CLS_KEY) begin
      case (hdr[3:0])
        4'd0, 4'd1:       len = 7'd4;
        4'd2:             len = 7'd10;
        4'd3, 4'd4, 4'd5: len = 7'd64;
        default:          len = 7'd1;
      endcase
    end else begin
      case (hdr[4:0])
        5'd0, 5'd1, 5'd2, 5'd8, 5'd9: len = 7'd4;
        5'd5, 5'd6:                   len = 7'd8;
        5'd12, 5'd13, 5'd14:          len = 7'd5;
        5'd4:                         len = 7'd14;
        5'd7:                         len = 7'd3;
        5'd16:                        len = 7'd2;
        default:                      len = 7'd1;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/burst_buffer.sv
// Write-payload staging buffer: words are appended in arrival order and read
// back by index while the command streams to the controller.
module burst_buffer
  import ccp_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  rd_idx_i,
  output logic [3:0]  count_o,
  output logic [31:0] rd_data_o
);

  logic [31:0] mem_q [MAX_WR_BURST];
  logic [3:0]  wrPtr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      for (int i = 0; i < MAX_WR_BURST; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      wrPtr_q <= '0;
    end else if (push_i && (wrPtr_q < 4'(MAX_WR_BURST))) begin
      mem_q[wrPtr_q] <= data_i;
      wrPtr_q        <= wrPtr_q + 4'd1;
    end
  end

  assign count_o   = wrPtr_q;
  assign rd_data_o = (rd_idx_i < 4'(MAX_WR_BURST)) ? mem_q[rd_idx_i] : '0;

endmodule

// File: rtl/ccp_cmd_arbiter.sv
// Round-robin owner of the coprocessor command port: grants one requester at a
// time, buffers write payloads, issues header plus burst and returns read data.
module ccp_cmd_arbiter
  import ccp_pkg::*;
#(
  parameter int N            = 4,
  parameter int STARTUP_WAIT = 66
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req_i,
  input  logic [32*N-1:0] req_hdr_i,
  output logic [N-1:0]    grant_o,
  input  logic [32*N-1:0] wr_data_i,
  input  logic [N-1:0]    wr_valid_i,
  output logic [N-1:0]    wr_ready_o,
  output logic [31:0]     rd_data_o,
  output logic [N-1:0]    rd_valid_o,
  output logic [N-1:0]    done_o,
  output logic [31:0]     instr_out_o,
  input  logic [31:0]     ctrl_out_i
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [IDXW-1:0] lastWin_q, lastWin_d;
  logic [31:0]     hdr_q, hdr_d;
  logic [6:0]      len_q, len_d;
  logic [6:0]      runCnt_q, runCnt_d;
  logic [15:0]     waitCnt_q, waitCnt_d;
  logic            nopDone_q, nopDone_d;

  logic [31:0]     hdrArr [N];
  logic [31:0]     wrDataArr [N];
  logic            winFound;
  logic [IDXW-1:0] winIdx;
  logic [IDXW-1:0] cand;
  logic [31:0]     winHdr;
  logic [N-1:0]    ownerMask;
  logic            wrReadyOwn;
  logic            push;
  logic            lastWord;
  logic            bufClear;
  logic [3:0]      wrCount;
  logic [31:0]     bufData;
  logic            isRead;
  logic            isWrite;
  logic            inTxn;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      hdrArr[i]    = req_hdr_i[32*i +: 32];
      wrDataArr[i] = wr_data_i[32*i +: 32];
    end
  end

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    cand     = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDXW'((int'(lastWin_q) + i) % N);
      if (!winFound && req_i[cand]) begin
        winFound = 1'b1;
        winIdx   = cand;
      end
    end
  end

  assign winHdr     = hdrArr[winIdx];
  assign ownerMask  = {{(N-1){1'b0}}, 1'b1} << owner_q;
  assign isRead     = (hdr_q[31:30] == CLS_READ);
  assign isWrite    = (hdr_q[31:30] == CLS_WRITE);
  assign wrReadyOwn = (state_q == ST_COLLECT) && ({3'b000, wrCount} < len_q);
  assign push       = wrReadyOwn && wr_valid_i[owner_q];
  assign lastWord   = push && (({3'b000, wrCount} + 7'd1) == len_q);

  burst_buffer u_buffer (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (bufClear),
    .push_i    (push),
    .data_i    (wrDataArr[owner_q]),
    .rd_idx_i  (runCnt_q[3:0]),
    .count_o   (wrCount),
    .rd_data_o (bufData)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_WAIT;
      owner_q   <= '0;
      lastWin_q <= IDXW'(N - 1);
      hdr_q     <= NOP_WORD;
      len_q     <= 7'd1;
      runCnt_q  <= '0;
      waitCnt_q <= '0;
      nopDone_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lastWin_q <= lastWin_d;
      hdr_q     <= hdr_d;
      len_q     <= len_d;
      runCnt_q  <= runCnt_d;
      waitCnt_q <= waitCnt_d;
      nopDone_q <= nopDone_d;
    end
  end

  // A no-op grant completes in IDLE; arbitration pauses during its done cycle
  // so the requester can drop req before being considered again.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lastWin_d = lastWin_q;
    hdr_d     = hdr_q;
    len_d     = len_q;
    runCnt_d  = runCnt_q;
    waitCnt_d = waitCnt_q;
    nopDone_d = 1'b0;
    bufClear  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        waitCnt_d = waitCnt_q + 16'd1;
        if (waitCnt_q == 16'(STARTUP_WAIT - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!nopDone_q && winFound) begin
          owner_d   = winIdx;
          lastWin_d = winIdx;
          hdr_d     = winHdr;
          len_d     = burst_len(winHdr);
          bufClear  = 1'b1;
          case (cmd_class_e'(winHdr[31:30]))
            CLS_NOP:   nopDone_d = 1'b1;
            CLS_WRITE: state_d   = ST_COLLECT;
            default:   state_d   = ST_ISSUE;
          endcase
        end
      end
      ST_COLLECT: begin
        if (lastWord) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        runCnt_d = '0;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        runCnt_d = runCnt_q + 7'd1;
        if (runCnt_q == (len_q - 7'd1)) state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  assign inTxn = (state_q == ST_COLLECT) || (state_q == ST_ISSUE) ||
                 (state_q == ST_RUN) || (state_q == ST_GAP);

  // Read words trail the header by two cycles, so valid skips the first RUN cycle.
  always_comb begin
    grant_o     = (inTxn || nopDone_q) ? ownerMask : '0;
    done_o      = ((state_q == ST_GAP) || nopDone_q) ? ownerMask : '0;
    wr_ready_o  = wrReadyOwn ? ownerMask : '0;
    rd_valid_o  = '0;
    rd_data_o   = ctrl_out_i;
    instr_out_o = NOP_WORD;
    if (isRead && (((state_q == ST_RUN) && (runCnt_q != 7'd0)) || (state_q == ST_GAP))) begin
      rd_valid_o = ownerMask;
    end
    if (state_q == ST_ISSUE) begin
      instr_out_o = hdr_q;
    end else if ((state_q == ST_RUN) && isWrite) begin
      instr_out_o = bufData;
    end
  end

endmodule

// File: tb/tb_ccp_cmd_arbiter.sv
// Bench for ccp_cmd_arbiter: table of commands replayed through a scoreboard,
// plus startup, round-robin and reset-abort sequences.
module tb_ccp_cmd_arbiter;

  localparam int          N       = 4;
  localparam int          STARTUP = 66;
  localparam logic [31:0] NOP     = 32'hC000_0000;

  logic            clock;
  logic            reset;
  logic [N-1:0]    req;
  logic [32*N-1:0] reqHdr;
  logic [N-1:0]    grant;
  logic [32*N-1:0] wrData;
  logic [N-1:0]    wrValid;
  logic [N-1:0]    wrReady;
  logic [31:0]     rdData;
  logic [N-1:0]    rdValid;
  logic [N-1:0]    done;
  logic [31:0]     instrOut;
  logic [31:0]     ctrlOut;

  ccp_cmd_arbiter #(.N(N), .STARTUP_WAIT(STARTUP)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_i       (req),
    .req_hdr_i   (reqHdr),
    .grant_o     (grant),
    .wr_data_i   (wrData),
    .wr_valid_i  (wrValid),
    .wr_ready_o  (wrReady),
    .rd_data_o   (rdData),
    .rd_valid_o  (rdValid),
    .done_o      (done),
    .instr_out_o (instrOut),
    .ctrl_out_i  (ctrlOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          who;
    logic [31:0] hdr;
    int          len;
    int          validMod;
    bit          dropEarly;
  } vec_t;

  vec_t        vecs [11];
  logic [31:0] instrQ [$];
  logic [31:0] rdQ [$];
  int          errors = 0;
  int          checks = 0;
  int          rrOrder [5] = '{0, 1, 2, 3, 0};

  task automatic compare32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic compareN(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic compareInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [N-1:0] oneHot(input int who);
    logic [N-1:0] m;
    m      = '0;
    m[who] = 1'b1;
    return m;
  endfunction

  // Raise a request, confirm the one-cycle grant, and feed write payload until the burst is full.
  task automatic applyStimulus(input int i);
    vec_t        v;
    int          collected;
    int          c;
    bit          vld;
    logic [31:0] word;
    v = vecs[i];
    req[v.who]              = 1'b1;
    reqHdr[v.who*32 +: 32]  = v.hdr;
    instrQ.push_back(v.hdr);
    tick;
    compareN("grant_latency", grant, oneHot(v.who));
    if (v.hdr[31:30] == 2'b01) begin
      collected = 0;
      c         = 0;
      while (collected < v.len && c < 200) begin
        vld  = (v.validMod == 0) || ((c % v.validMod) != 1);
        word = 32'hD000_0000 | (32'(i) << 16) | 32'(collected);
        wrValid[v.who]         = vld;
        wrData[v.who*32 +: 32] = word;
        #1;
        compareN("wr_ready_collect", wrReady, oneHot(v.who));
        if (vld) begin
          instrQ.push_back(word);
          collected++;
        end
        tick;
        c++;
      end
      wrValid = '0;
      compareInt("collected_words", collected, v.len);
      compareN("wr_ready_full", wrReady, '0);
    end
  endtask

  // Walk from the ISSUE cycle to the IDLE cycle after GAP, acting as the controller.
  task automatic checkOutput(input int i);
    vec_t        v;
    int          len;
    bit          isRead;
    bit          isWrite;
    logic [31:0] expInstr;
    v       = vecs[i];
    len     = v.len;
    isRead  = (v.hdr[31:30] == 2'b00);
    isWrite = (v.hdr[31:30] == 2'b01);
    for (int c = 0; c <= len + 2; c++) begin
      if (isRead && c >= 2 && c <= len + 1) begin
        ctrlOut = 32'hA000_0000 | (32'(i) << 8) | 32'(c - 2);
        rdQ.push_back(ctrlOut);
      end else begin
        ctrlOut = 32'h5A5A_0000 | 32'(c);
      end
      #1;
      if (c == 0 || (isWrite && c <= len)) begin
        expInstr = (instrQ.size() > 0) ? instrQ.pop_front() : 32'hBAD0_0000;
      end else begin
        expInstr = NOP;
      end
      compare32("instr_out", instrOut, expInstr);
      compareN("grant_hold", grant, (c <= len + 1) ? oneHot(v.who) : {N{1'b0}});
      compareN("done_pulse", done, (c == len + 1) ? oneHot(v.who) : {N{1'b0}});
      compareN("rd_valid", rdValid,
               (isRead && c >= 2 && c <= len + 1) ? oneHot(v.who) : {N{1'b0}});
      if (rdValid[v.who] && rdQ.size() > 0) begin
        compare32("rd_data", rdData, rdQ.pop_front());
      end
      if (c == len + 1 || (v.dropEarly && c == 1)) req[v.who] = 1'b0;
      tick;
    end
    compareInt("instr_queue_drained", instrQ.size(), 0);
    compareInt("read_queue_drained", rdQ.size(), 0);
    instrQ.delete();
    rdQ.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{who: 0, hdr: 32'h0000_0007, len: 3,  validMod: 0, dropEarly: 1'b0};
    vecs[1]  = '{who: 1, hdr: 32'h4000_000C, len: 5,  validMod: 3, dropEarly: 1'b0};
    vecs[2]  = '{who: 2, hdr: 32'h8000_0003, len: 64, validMod: 0, dropEarly: 1'b0};
    vecs[3]  = '{who: 3, hdr: 32'h0000_0010, len: 2,  validMod: 0, dropEarly: 1'b1};
    vecs[4]  = '{who: 0, hdr: 32'h4000_0004, len: 14, validMod: 0, dropEarly: 1'b0};
    vecs[5]  = '{who: 1, hdr: 32'h0000_0013, len: 1,  validMod: 0, dropEarly: 1'b0};
    vecs[6]  = '{who: 2, hdr: 32'h8000_0008, len: 1,  validMod: 0, dropEarly: 1'b0};
    vecs[7]  = '{who: 0, hdr: 32'h8000_0002, len: 10, validMod: 0, dropEarly: 1'b0};
    vecs[8]  = '{who: 3, hdr: 32'h4000_0005, len: 8,  validMod: 2, dropEarly: 1'b0};
    vecs[9]  = '{who: 1, hdr: 32'h4000_000C, len: 5,  validMod: 0, dropEarly: 1'b0};
    vecs[10] = '{who: 2, hdr: 32'h4000_0007, len: 3,  validMod: 0, dropEarly: 1'b0};

    reset   = 1'b1;
    req     = '0;
    reqHdr  = '0;
    wrValid = '0;
    wrData  = '0;
    ctrlOut = 32'h1234_5678;
    req[0]        = 1'b1;
    reqHdr[31:0]  = vecs[0].hdr;
    #3;
    compareN("reset_grant", grant, '0);
    compareN("reset_done", done, '0);
    compareN("reset_wr_ready", wrReady, '0);
    compareN("reset_rd_valid", rdValid, '0);
    compare32("reset_instr", instrOut, NOP);
    compare32("reset_rd_passthru", rdData, 32'h1234_5678);

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 1; k <= STARTUP; k++) begin
      tick;
      compareN("startup_gate", grant, '0);
    end
    tick;
    compareN("first_grant", grant, oneHot(0));
    instrQ.push_back(vecs[0].hdr);
    checkOutput(0);

    for (int i = 1; i <= 8; i++) begin
      applyStimulus(i);
      checkOutput(i);
    end

    $display("[TB] round-robin over no-op commands");
    for (int r = 0; r < N; r++) begin
      req[r]             = 1'b1;
      reqHdr[r*32 +: 32] = 32'hC000_0000;
    end
    for (int k = 0; k < 5; k++) begin
      tick;
      compareN("rr_grant", grant, oneHot(rrOrder[k]));
      compareN("rr_done", done, oneHot(rrOrder[k]));
      compare32("rr_instr", instrOut, NOP);
      if (k == 4) req = '0;
      tick;
      compareN("rr_gap", grant, '0);
    end

    $display("[TB] reset during write RUN");
    applyStimulus(9);
    compare32("abort_issue", instrOut, instrQ.pop_front());
    tick;
    compare32("abort_run0", instrOut, instrQ.pop_front());
    tick;
    compare32("abort_run1", instrOut, instrQ.pop_front());
    reset = 1'b1;
    #1;
    compare32("abort_instr_nop", instrOut, NOP);
    compareN("abort_grant", grant, '0);
    compareN("abort_done", done, '0);
    compareN("abort_wr_ready", wrReady, '0);
    instrQ.delete();
    req = '0;
    tick;
    reset = 1'b0;
    for (int k = 0; k < 80; k++) begin
      tick;
      compareN("post_reset_quiet", grant | done, '0);
    end
    applyStimulus(10);
    checkOutput(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccp_cmd_arbiter.md
# ccp_cmd_arbiter

Round-robin arbiter and sequencer that shares the coprocessor controller's single 32-bit command port (`instruct` in, `out` back) between `N` requesters. It owns the controller's command timing: latches a requester's header, derives the burst length from the header, buffers write payloads so the controller never starves, streams read words back to the owner, and enforces idle gaps between commands. It sits between the host-side requesters and `instruct`/`out`.

## Interface
- `N`, default 4: number of requesters (2..8).
- `STARTUP_WAIT`, default 66: cycles after reset release before the first grant.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req` in N: request per requester, level, held until `done`.
- `req_hdr` in 32·N: header word per requester, slice i = [32i+31:32i], stable while `req[i]`.
- `grant` out N: one-hot owner, held from grant to `done`.
- `wr_data` in 32·N: write payload per requester.
- `wr_valid` in N / `wr_ready` out N: payload handshake; a word transfers when both are high.
- `rd_data` out 32: read word, shared by all requesters.
- `rd_valid` out N: one-hot qualifier for `rd_data`, owner only.
- `done` out N: one-cycle pulse to the owner at transaction end.
- `instr_out` out 32: drives controller `instruct`.
- `ctrl_out` in 32: from controller `out`.

## Operation
- Header class `hdr[31:30]`: 00 read, 01 write, 10 key expand, 11 no-op. Opcode `hdr[4:0]`, or `hdr[3:0]` for class 10.
- Burst length L, read/write: op 0,1,2,8,9→4; 5,6→8; 12,13,14→5; 4→14; 7→3; 16→2; others→1.
- Burst length L, key: op 0,1→4; 2→10; 3,4,5→64; others→1.
- Idle word NOP = 32'hC000_0000. `instr_out` = NOP except in ISSUE and in RUN for writes.
- States:
  - WAIT: startup counter.
  - IDLE
  - COLLECT
  - ISSUE
  - RUN
  - GAP
- WAIT→IDLE once the counter reaches `STARTUP_WAIT`. Every reset passes through WAIT. The controller has no reset of its own, and this lets a controller burst that was interrupted by reset run out.
- IDLE: if any `req`, pick the winner round-robin, searching from (last winner + 1) mod N; after reset the search starts at 0. Latch the header and L, and assert `grant` the next cycle.
  - Class 11 → `done` pulse in that same grant cycle, back to IDLE, nothing issued.
  - Class 01 → COLLECT.
  - Class 00 or 10 → ISSUE.
- COLLECT: `wr_ready[owner]`=1 while collected < L. Each handshake appends to the burst buffer at index 0..L-1. When collected = L, go to ISSUE. There is no timeout; stall indefinitely on `wr_valid`=0.
- ISSUE (cycle T): `instr_out` = latched header, one cycle → RUN.
- RUN (cycles T+1..T+L):
  - Write: `instr_out` = buffer[k] at T+1+k.
  - Read/key: `instr_out` = NOP.
  - → GAP.
- GAP (cycle T+L+1): `done[owner]` pulse, `grant` still held. → IDLE at T+L+2, where `grant` drops.
- Read return: `rd_data` = `ctrl_out` (combinational pass-through); `rd_valid[owner]`=1 on T+2..T+L+1, exactly L cycles. There is no backpressure; the requester must accept every word.
- A `req` that deasserts mid-transaction is ignored; the transaction completes.
- Requests arriving during a transaction wait; arbitration happens only in IDLE.

## Timing
- Reset values: `grant`, `wr_ready`, `rd_valid`, `done` = 0; `rd_data` follows `ctrl_out`; `instr_out` = NOP; state = WAIT; round-robin pointer = N-1.
- Reset mid-operation: immediate abort to WAIT, buffer discarded, no `done`.
- Request-to-grant latency: 1 cycle.
- Read/key: grant→ISSUE 1 cycle; header→`done` = L+1 cycles.
- Write: ISSUE follows the cycle in which the L-th word handshakes.
- Back-to-back commands: minimum header-to-header spacing is L+3 cycles (GAP, then IDLE, then the next grant).
- L counter is 7 bits (max 64). The buffer index is 4 bits (write max 14).

## Structure
- Package `ccp_pkg`:
  - class codes
  - NOP constant
  - `MAX_WR_BURST`=14
  - `burst_len(hdr)` function returning 7 bits
- `burst_len` is the single source of the length table shared with any future controller rework.
- Sub-module `burst_buffer`: 14×32 register file with write pointer and read index, clear on reset or when a new transaction is granted.
- Arbiter pointer logic stays inline.

## Test plan
- Startup gate: release reset with `req`=4'b0001 and header 32'h0000_0007. `grant` stays 0 for 66 cycles after release, then `grant`=0001.
- Read op 7 (header 32'h0000_0007, L=3), controller model returning A0,A1,A2: `rd_valid[0]` high for exactly 3 cycles carrying A0,A1,A2 at T+2..T+4; `done` at T+4.
- Write op 12 (header 32'h4000_000C, L=5) with `wr_valid` toggling 1,0,1,1,0,1,1: 5 words buffered; `instr_out` shows the header then the 5 words on consecutive cycles with no gaps; `done` at T+6.
- Key op 3 (header 32'h8000_0003, L=64): `instr_out` = NOP for 64 cycles after the header; `done` at T+65; no `rd_valid`.
- Round-robin: `req`=1111 held, all headers class 11. Grants go 0001, 0010, 0100, 1000, 0001, with a `done` pulse in each grant cycle.
- Reset mid-RUN of a write: `instr_out` = NOP the same cycle; `grant`/`done` = 0; no `done` after WAIT expires until a new `req`.
